// File: rtl/_div32.sv
// _div32: sequential 32-bit restoring divider, one quotient bit per clock, with RV32M sign/zero semantics.
module _div32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_d;
  logic sa, sb, bz, co;
  logic [4:0] cnt;
  logic [31:0] mb, qr, rr;
  logic [32:0] sh, t;
  // The partial remainder stays below |b|, so only the shifted value needs the 33rd bit.
  // With that bound, the MSB of the 33-bit trial result is exactly the borrow.
  always_comb begin
    sh = {rr, qr[31]};
    t = sh + {1'b1, ~mb} + 33'd1;
    co = ~t[32];
    state_d = state == IDLE ? (start ? CALC : IDLE) :
              state == CALC ? (&cnt ? DONE : CALC) : IDLE;
  end
  assign busy = state != IDLE || done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 5'd0;
      sa <= 1'b0;
      sb <= 1'b0;
      bz <= 1'b0;
      mb <= 32'd0;
      qr <= 32'd0;
      rr <= 32'd0;
      done <= 1'b0;
      q <= 32'd0;
      r <= 32'd0;
    end else begin
      state <= state_d;
      done <= state == DONE;
      if (state == IDLE && start) begin
        sa <= sgn & a[31];
        sb <= sgn & b[31];
        bz <= b == 32'd0;
        qr <= (sgn & a[31]) ? -a : a;
        mb <= (sgn & b[31]) ? -b : b;
        rr <= 32'd0;
        cnt <= 5'd0;
      end
      if (state == CALC) begin
        rr <= co ? t[31:0] : sh[31:0];
        qr <= {qr[30:0], co};
        cnt <= cnt + 5'd1;
      end
      if (state == DONE) begin
        q <= (sa ^ sb) && !bz ? -qr : qr;
        r <= sa ? -rr : rr;
      end
    end
  end
endmodule

// File: tb/tb__div32.sv
// tb__div32: directed and randomized checks of the sequential divider against an RV32M model.
module tb__div32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0, q, r;
  logic busy, done;
  int pass = 0, total = 0;
  logic [63:0] e;
  logic rs;
  logic [31:0] rx, ry;

  _div32 dut (.clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
              .busy(busy), .done(done), .q(q), .r(r));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    total++;
    assert (o === x) pass++;
    else $error("FAIL %s: got %h expected %h", tag, o, x);
  endtask

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return {32'hFFFF_FFFF, x};
    if (!s) return {x / y, x % y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
    return {$signed(x) / $signed(y), $signed(x) % $signed(y)};
  endfunction

  // Issues one start and waits for done; inj >= 0 re-asserts start with new operands mid-CALC.
  task automatic run(input logic s, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eq, input logic [31:0] er, input int inj, input string tag);
    int n, nb;
    sgn = s; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    nb = int'(busy);
    while (!done && n < 40) begin
      if (n == inj) begin
        start = 1'b1; a = 32'h5555_5555; b = 32'd3; sgn = ~s;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      nb += int'(busy);
    end
    chk({tag, ".lat"}, n, 33);
    chk({tag, ".busy"}, nb, 34);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".r"}, r, er);
  endtask

  initial begin
    int dn;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.q", q, 0);
    chk("rst.r", r, 0);
    run(0, 32'd100, 32'd7, 32'd14, 32'd2, -1, "udiv");
    run(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1, "sneg_a");
    run(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, -1, "sneg_b");
    run(0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, -1, "div0_u");
    run(1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, -1, "div0_s");
    run(1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, -1, "div0_sneg");
    run(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, -1, "ovf");
    run(0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, -1, "wide");
    run(0, 32'd1000, 32'd7, 32'd142, 32'd6, 5, "restart");
    @(posedge clk); #1;
    chk("idle.busy", busy, 0);
    chk("idle.done", done, 0);
    sgn = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.q", q, 0);
    chk("abort.r", r, 0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      dn += int'(done);
    end
    chk("abort.nodone", dn, 0);
    run(1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, -1, "after_rst");
    for (int i = 0; i < 400; i++) begin
      rs = 1'($urandom);
      rx = $urandom;
      ry = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom;
      e = ref_div(rs, rx, ry);
      run(rs, rx, ry, e[63:32], e[31:0], -1, "rnd");
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
